kp_kernel_ctrl: RTL and testbench



---
 rtl/kp_kernel_pkg.sv | 31 +++
 rtl/kp_line_buffer.sv | 30 +++
 rtl/kp_kernel_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_kp_kernel_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kp_kernel_pkg.sv
// Shared types and constants for the 3x3 kernel line-buffer controller.
// Optional embedded assertions in kp_kernel_ctrl are enabled by KP_KERNEL_ASSERT_EN.
package kp_kernel_pkg;

   typedef enum logic [0:0] {
      StFill = 1'b0,
      StRead = 1'b1
   } kp_state_e;

   localparam int unsigned NUM_LINES = 3;

   // Default geometry; the top module derives its own widths from its parameters.
   localparam int unsigned KP_LINE_LENGTH = 480;
   localparam int unsigned KP_LINE_COUNT  = 480;
   localparam int unsigned KP_DATA_WIDTH  = 16;

   // Width needed to index n items, never below one bit.
   function automatic int unsigned kp_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned COL_W      = kp_width(KP_LINE_LENGTH);
   localparam int unsigned LINE_CNT_W = kp_width(KP_LINE_COUNT);
   localparam int unsigned SEL_W      = kp_width(NUM_LINES);

   // Next buffer in the rotation, modulo NUM_LINES.
   function automatic logic [SEL_W-1:0] kp_sel_inc(input logic [SEL_W-1:0] sel);
      return (sel == SEL_W'(NUM_LINES - 1)) ? '0 : sel + 1'b1;
   endfunction

endpackage

// File: rtl/kp_line_buffer.sv
// One image line of storage: synchronous write port, registered read port.
module kp_line_buffer
   import kp_kernel_pkg::*;
#(
   parameter int unsigned Depth = KP_LINE_LENGTH,
   parameter int unsigned Width = KP_DATA_WIDTH,
   localparam int unsigned AddrW = kp_width(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] rdata_q;

   // Storage has no reset; contents are only read after being written.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/kp_kernel_ctrl.sv
// 3x3 neighbourhood line-buffer controller: fills three rotating line buffers through a
// request/valid handshake, then streams one column of three row triplets per cycle with
// left/right edge replication. Define KP_KERNEL_ASSERT_EN to compile in embedded assertions.
module kp_kernel_ctrl
   import kp_kernel_pkg::*;
#(
   parameter int unsigned LINE_LENGTH = KP_LINE_LENGTH,
   parameter int unsigned LINE_COUNT  = KP_LINE_COUNT,
   parameter int unsigned DATA_WIDTH  = KP_DATA_WIDTH
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_valid,
   output logic                    o_req,
   output logic [3*DATA_WIDTH-1:0] o_r0_data,
   output logic [3*DATA_WIDTH-1:0] o_r1_data,
   output logic [3*DATA_WIDTH-1:0] o_r2_data,
   output logic                    o_valid
);

   localparam int unsigned W        = DATA_WIDTH;
   localparam int unsigned ColW     = kp_width(LINE_LENGTH);
   localparam int unsigned RdW      = kp_width(LINE_LENGTH + 2);
   localparam int unsigned FillFull = NUM_LINES * LINE_LENGTH;
   localparam int unsigned FillW    = kp_width(FillFull);
   localparam int unsigned LineW    = kp_width(LINE_COUNT);

   localparam logic [ColW-1:0]  LastCol  = ColW'(LINE_LENGTH - 1);
   localparam logic [LineW-1:0] LastLine = LineW'(LINE_COUNT - 1);
   localparam logic [FillW-1:0] FillLast = FillW'(FillFull - 1);
   localparam logic [FillW-1:0] FillTwo  = FillW'(2 * LINE_LENGTH);
   localparam logic [RdW-1:0]   RdLast   = RdW'(LINE_LENGTH + 1);

   kp_state_e                       state_q, state_d;
   logic [FillW-1:0]                fill_q, fill_d;
   logic [FillW-1:0]                outst_q, outst_d;
   logic                            req_q, req_d;
   logic [SEL_W-1:0]                old_sel_q, old_sel_d;
   logic [SEL_W-1:0]                wr_sel_q, wr_sel_d;
   logic [ColW-1:0]                 wr_col_q, wr_col_d;
   logic [LineW-1:0]                line_q, line_d;
   logic [RdW-1:0]                  rd_cnt_q, rd_cnt_d;
   logic [NUM_LINES-1:0][W-1:0]     prev1_q, prev1_d;
   logic [NUM_LINES-1:0][W-1:0]     prev2_q, prev2_d;
   logic [NUM_LINES-1:0][3*W-1:0]   win_q, win_d;
   logic                            valid_q, valid_d;

   logic                            accept;
   logic [ColW-1:0]                 rd_addr;
   logic [W-1:0]                    ram_rd   [NUM_LINES];
   logic [W-1:0]                    row_data [NUM_LINES];
   logic [SEL_W-1:0]                row_sel  [NUM_LINES];
   logic [W-1:0]                    cur;

   assign accept  = (state_q == StFill) && i_valid;
   assign rd_addr = (rd_cnt_q < RdW'(LINE_LENGTH)) ? ColW'(rd_cnt_q) : '0;

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_buf
      kp_line_buffer #(
         .Depth (LINE_LENGTH),
         .Width (DATA_WIDTH)
      ) u_buf (
         .clk_i   (i_clk),
         .we_i    (accept && (wr_sel_q == SEL_W'(g))),
         .waddr_i (wr_col_q),
         .wdata_i (i_data),
         .raddr_i (rd_addr),
         .rdata_o (ram_rd[g])
      );
   end

   // Map physical buffers onto oldest/middle/newest roles.
   always_comb begin
      row_sel[0] = old_sel_q;
      row_sel[1] = kp_sel_inc(old_sel_q);
      row_sel[2] = kp_sel_inc(kp_sel_inc(old_sel_q));
      for (int unsigned r = 0; r < NUM_LINES; r++) begin
         case (row_sel[r])
            SEL_W'(0): row_data[r] = ram_rd[0];
            SEL_W'(1): row_data[r] = ram_rd[1];
            default:   row_data[r] = ram_rd[2];
         endcase
      end
   end

   // Fill/read sequencing, pointer rotation and window shifting.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      outst_d   = outst_q + FillW'(req_q) - FillW'(accept);
      req_d     = 1'b0;
      old_sel_d = old_sel_q;
      wr_sel_d  = wr_sel_q;
      wr_col_d  = wr_col_q;
      line_d    = line_q;
      rd_cnt_d  = rd_cnt_q;
      prev1_d   = prev1_q;
      prev2_d   = prev2_q;
      win_d     = win_q;
      valid_d   = 1'b0;
      cur       = '0;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               if (wr_col_q == LastCol) begin
                  wr_col_d = '0;
                  wr_sel_d = kp_sel_inc(wr_sel_q);
                  line_d   = (line_q == LastLine) ? '0 : line_q + 1'b1;
               end else begin
                  wr_col_d = wr_col_q + 1'b1;
               end
               if (fill_q == FillLast) begin
                  // Oldest line is already counted as released once the read begins.
                  state_d  = StRead;
                  fill_d   = FillTwo;
                  rd_cnt_d = '0;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            // Never request more than the pixels still missing.
            req_d = (state_d == StFill) &&
                    (({1'b0, fill_d} + {1'b0, outst_d}) < (FillW + 1)'(FillFull));
         end
         StRead: begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            for (int unsigned r = 0; r < NUM_LINES; r++) begin
               // One extra step after the last read replicates the right edge.
               cur = (rd_cnt_q == RdLast) ? prev1_q[r] : row_data[r];
               if (rd_cnt_q == RdW'(1)) begin
                  prev1_d[r] = row_data[r];
                  prev2_d[r] = row_data[r];
               end else if (rd_cnt_q >= RdW'(2)) begin
                  win_d[r]   = {prev2_q[r], prev1_q[r], cur};
                  prev2_d[r] = prev1_q[r];
                  prev1_d[r] = cur;
                  valid_d    = 1'b1;
               end
            end
            if (rd_cnt_q == RdLast) begin
               state_d = StFill;
               if (line_q == '0) begin
                  // Whole frame consumed: start over with a three-line fill.
                  fill_d    = '0;
                  old_sel_d = '0;
                  wr_sel_d  = '0;
                  wr_col_d  = '0;
               end else begin
                  old_sel_d = kp_sel_inc(old_sel_q);
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= StFill;
         fill_q    <= '0;
         outst_q   <= '0;
         req_q     <= 1'b0;
         old_sel_q <= '0;
         wr_sel_q  <= '0;
         wr_col_q  <= '0;
         line_q    <= '0;
         rd_cnt_q  <= '0;
         prev1_q   <= '0;
         prev2_q   <= '0;
         win_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         outst_q   <= outst_d;
         req_q     <= req_d;
         old_sel_q <= old_sel_d;
         wr_sel_q  <= wr_sel_d;
         wr_col_q  <= wr_col_d;
         line_q    <= line_d;
         rd_cnt_q  <= rd_cnt_d;
         prev1_q   <= prev1_d;
         prev2_q   <= prev2_d;
         win_q     <= win_d;
         valid_q   <= valid_d;
      end
   end

   assign o_req     = req_q;
   assign o_valid   = valid_q;
   assign o_r0_data = win_q[0];
   assign o_r1_data = win_q[1];
   assign o_r2_data = win_q[2];

`ifdef KP_KERNEL_ASSERT_EN
   logic [RdW-1:0] vld_run_q;

   // Number of consecutive o_valid cycles preceding the current one.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_run_q <= '0;
      end else if (valid_q) begin
         vld_run_q <= vld_run_q + 1'b1;
      end else begin
         vld_run_q <= '0;
      end
   end

   a_fill_bound: assert property (@(posedge i_clk) disable iff (!i_rstn)
      ({1'b0, fill_q} < (FillW + 1)'(FillFull)));
   a_valid_run: assert property (@(posedge i_clk) disable iff (!i_rstn)
      valid_q |-> (vld_run_q < RdW'(LINE_LENGTH)));
   a_no_unsolicited: assert property (@(posedge i_clk) disable iff (!i_rstn)
      i_valid |-> (outst_q != '0));
`else
`endif

endmodule

// File: tb/tb_kp_kernel_ctrl.sv
// Randomized self-checking bench for kp_kernel_ctrl with a frame-level window model.
module tb_kp_kernel_ctrl;

   localparam int L  = 480;
   localparam int LC = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          o_req;
   logic [3*DW-1:0] o_r0_data, o_r1_data, o_r2_data;
   logic          o_valid;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;
   int unsigned last_pix_cyc = 0;
   int unsigned max_dly = 0;
   int          rows_done = 0;

   // Pixels of the current frame as delivered upstream.
   logic [DW-1:0] img [LC][L];
   int            rl = 0;
   int            rc = 0;

   kp_kernel_ctrl #(
      .LINE_LENGTH (L),
      .LINE_COUNT  (LC),
      .DATA_WIDTH  (DW)
   ) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_req     (o_req),
      .o_r0_data (o_r0_data),
      .o_r1_data (o_r1_data),
      .o_r2_data (o_r2_data),
      .o_valid   (o_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Required window of a line: {p[c-1], p[c], p[c+1]} with edge replication.
   function automatic logic [3*DW-1:0] exp_win(input int line, input int col);
      logic [DW-1:0] a, b, c;
      b = img[line][col];
      a = b;
      c = b;
      if (col > 0) a = img[line][col-1];
      if (col < L - 1) c = img[line][col+1];
      return {a, b, c};
   endfunction

   // Upstream source: answers each request in order after 1..1+max_dly cycles.
   initial begin
      int unsigned due_q[$];
      int unsigned last_due;
      int unsigned d;
      last_due = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rstn) begin
            due_q.delete();
            i_valid = 1'b0;
            rl = 0;
            rc = 0;
            last_due = cyc;
         end else begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
               void'(due_q.pop_front());
               i_valid = 1'b1;
               i_data = DW'($urandom);
               img[rl][rc] = i_data;
               last_pix_cyc = cyc;
               rc++;
               if (rc == L) begin
                  rc = 0;
                  rl = (rl == LC - 1) ? 0 : rl + 1;
               end
            end else begin
               i_valid = 1'b0;
               i_data = DW'($urandom);
            end
            if (o_req) begin
               d = cyc + 1 + $urandom_range(max_dly, 0);
               if (d <= last_due) d = last_due + 1;
               due_q.push_back(d);
               last_due = d;
            end
         end
      end
   end

   // Output compare against the model on every falling edge.
   initial begin
      int  out_row;
      int  out_col;
      int  run;
      int  reqc;
      bit  pv;
      out_row = 0; out_col = 0; run = 0; reqc = 0; pv = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (!rstn) begin
            check("rst_valid", 64'(o_valid), 64'd0);
            check("rst_req", 64'(o_req), 64'd0);
            check("rst_data", 64'(o_r0_data | o_r1_data | o_r2_data), 64'd0);
            out_row = 0; out_col = 0; run = 0; reqc = 0; pv = 1'b0;
         end else begin
            check("fill_bound", 64'(int'(dut.fill_q) < 3 * L), 64'd1);
            if (o_req) reqc++;
            if (o_valid) begin
               if (!pv) begin
                  check("req_count", 64'(reqc), 64'((out_row == 0) ? 3 * L : L));
                  reqc = 0;
                  check("fill_to_valid", 64'((cyc - last_pix_cyc) <= 4), 64'd1);
               end
               check("req_in_read", 64'(o_req), 64'd0);
               check("r0", 64'(o_r0_data), 64'(exp_win(out_row, out_col)));
               check("r1", 64'(o_r1_data), 64'(exp_win(out_row + 1, out_col)));
               check("r2", 64'(o_r2_data), 64'(exp_win(out_row + 2, out_col)));
               run++;
               out_col++;
               if (out_col == L) begin
                  out_col = 0;
                  rows_done++;
                  out_row = (out_row == LC - 3) ? 0 : out_row + 1;
               end
            end else if (pv) begin
               check("valid_run", 64'(run), 64'(L));
               run = 0;
            end
            pv = o_valid;
         end
      end
   end

   // Scenario sequencing plus hand-computed expectations for the first row.
   initial begin
      int t;
      int r;
      rstn = 1'b0;
      repeat (8) @(negedge clk);
      check("reset_outputs", 64'({o_req, o_valid}), 64'd0);
      check("reset_r0", 64'(o_r0_data), 64'd0);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("req_after_release", 64'(o_req), 64'd1);

      t = 0;
      while (!o_valid && t < 5000) begin @(negedge clk); t++; end
      check("first_valid_seen", 64'(o_valid), 64'd1);
      check("first_r0_col0", 64'(o_r0_data), 64'({img[0][0], img[0][0], img[0][1]}));
      check("first_r2_col0", 64'(o_r2_data), 64'({img[2][0], img[2][0], img[2][1]}));
      @(negedge clk);
      check("first_r1_col1", 64'(o_r1_data), 64'({img[1][0], img[1][1], img[1][2]}));
      repeat (L - 2) @(negedge clk);
      check("first_r0_col479", 64'(o_r0_data),
            64'({img[0][L-2], img[0][L-1], img[0][L-1]}));
      @(negedge clk);
      check("valid_low_after_row", 64'(o_valid), 64'd0);

      t = 0;
      while (rows_done < LC - 2 && t < 20000) begin @(negedge clk); t++; end
      check("frame1_rows", 64'(rows_done >= LC - 2), 64'd1);

      max_dly = 5;
      t = 0;
      while (rows_done < 2 * (LC - 2) && t < 40000) begin @(negedge clk); t++; end
      check("frame2_rows", 64'(rows_done >= 2 * (LC - 2)), 64'd1);

      t = 0;
      while (o_valid && t < 5000) begin @(negedge clk); t++; end
      t = 0;
      while (!o_valid && t < 5000) begin @(negedge clk); t++; end
      check("frame3_valid_seen", 64'(o_valid), 64'd1);
      repeat (200) @(negedge clk);
      #1 rstn = 1'b0;
      @(negedge clk);
      check("midrow_reset_valid", 64'(o_valid), 64'd0);
      repeat (2) @(negedge clk);
      r = rows_done;
      #1 rstn = 1'b1;
      t = 0;
      while (rows_done < r + 1 && t < 10000) begin @(negedge clk); t++; end
      check("row_after_reset", 64'(rows_done >= r + 1), 64'd1);
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
